// File: rtl/tick_timer.sv
// Interval timer counting prescaler ticks to a latched period; all outputs registered, 1-cycle latency.
// No backpressure: tick_in/start/stop are sampled every clk, priority stop > start > tick_in.
module tick_timer #(
  parameter int CNT_W = 8,
  parameter int EXP_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick_in,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] period,
  input  logic             periodic,
  output logic [CNT_W-1:0] count,
  output logic [1:0]       state,
  output logic             busy,
  output logic             expire,
  output logic [EXP_W-1:0] nexp,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    DONE  = 2'b11
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_d, period_q, period_d;
  logic             periodic_q, periodic_d;
  logic             busy_d, expire_d, err_d;
  logic [EXP_W-1:0] nexp_d;
  logic             period_ok;
  logic             at_term;

  assign period_ok = (period != '0);
  // count stays below period_q while running, so the increment cannot wrap here
  assign at_term   = ((count + CNT_W'(1)) == period_q);
  assign state     = state_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      count      <= '0;
      period_q   <= '0;
      periodic_q <= 1'b0;
      busy       <= 1'b0;
      expire     <= 1'b0;
      nexp       <= '0;
      err        <= 1'b0;
    end else begin
      state_q    <= state_d;
      count      <= count_d;
      period_q   <= period_d;
      periodic_q <= periodic_d;
      busy       <= busy_d;
      expire     <= expire_d;
      nexp       <= nexp_d;
      err        <= err_d;
    end
  end

  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE, DONE: begin
        if (stop)                    state_d = IDLE;
        else if (start && period_ok) state_d = RUN;
        else                         state_d = state_q;
      end
      RUN: begin
        if (stop)                                  state_d = PAUSE;
        else if (tick_in && at_term && !periodic_q) state_d = DONE;
        else                                       state_d = RUN;
      end
      PAUSE: begin
        if (stop)       state_d = IDLE;
        else if (start) state_d = RUN;
        else            state_d = PAUSE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d    = count;
    period_d   = period_q;
    periodic_d = periodic_q;
    expire_d   = 1'b0;
    nexp_d     = nexp;
    err_d      = err;
    case (state_q)
      IDLE, DONE: begin
        if (stop) begin
          count_d = '0;
        end else if (start) begin
          if (period_ok) begin
            period_d   = period;
            periodic_d = periodic;
            count_d    = '0;
            nexp_d     = '0;
            err_d      = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (!stop && tick_in) begin
          if (at_term) begin
            expire_d = 1'b1;
            if (nexp != {EXP_W{1'b1}}) nexp_d = nexp + EXP_W'(1);
            // one-shot parks at the terminal count so DONE reports the full period
            count_d = periodic_q ? '0 : period_q;
          end else begin
            count_d = count + CNT_W'(1);
          end
        end
      end
      PAUSE: begin
        if (stop) count_d = '0;
      end
      default: count_d = '0;
    endcase
    busy_d = (state_d == RUN) || (state_d == PAUSE);
  end

endmodule

// File: tb/tb_tick_timer.sv
// Directed-vector bench for tick_timer: driver queues hand-computed expectations, monitor compares per cycle.
module tb_tick_timer;

  localparam int I = 0, R = 1, P = 2, D = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick_in = 1'b0, start = 1'b0, stop = 1'b0, periodic = 1'b0;
  logic [7:0] period = 8'd0;
  logic [7:0] count;
  logic [1:0] state;
  logic       busy, expire, err;
  logic [3:0] nexp;

  tick_timer #(.CNT_W(8), .EXP_W(4)) dut (
    .clk(clk), .reset(reset), .tick_in(tick_in), .start(start), .stop(stop),
    .period(period), .periodic(periodic), .count(count), .state(state),
    .busy(busy), .expire(expire), .nexp(nexp), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0, n_bad = 0, vid = 0;

  typedef struct {
    logic [16:0] v;
    int          cyc;
    int          id;
  } exp_t;
  exp_t q[$];

  wire [16:0] act = {count, state, busy, expire, nexp, err};

  function automatic logic [16:0] pack(input int c, input int st, input int b,
                                       input int e, input int n, input int er);
    return {8'(c), 2'(st), 1'(b), 1'(e), 4'(n), 1'(er)};
  endfunction

  // One clk of stimulus plus the outputs expected after the following rising edge.
  task automatic step(input int t, input int s, input int p, input int c, input int st,
                      input int b, input int e, input int n, input int er);
    exp_t x;
    @(negedge clk);
    tick_in = (t != 0);
    start   = (s != 0);
    stop    = (p != 0);
    x.v   = pack(c, st, b, e, n, er);
    x.cyc = cyc + 1;
    x.id  = vid;
    vid++;
    q.push_back(x);
  endtask

  task automatic check_now(input string nm, input logic [16:0] want);
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got {cnt,st,busy,exp,nexp,err}=%h want %h", nm, act, want);
    end
  endtask

  always @(posedge clk) begin
    exp_t x;
    #2;
    while (q.size() > 0 && q[0].cyc < cyc) begin
      x = q.pop_front();
      n_vec++;
      n_bad++;
      $display("FAIL vec%0d: never sampled (due cycle %0d)", x.id, x.cyc);
    end
    if (q.size() > 0 && q[0].cyc == cyc) begin
      x = q.pop_front();
      n_vec++;
      if (act !== x.v) begin
        n_bad++;
        $display("FAIL vec%0d: got cnt=%0d st=%0d busy=%0d exp=%0d nexp=%0d err=%0d, want cnt=%0d st=%0d busy=%0d exp=%0d nexp=%0d err=%0d",
                 x.id, count, state, busy, expire, nexp, err,
                 x.v[16:9], x.v[8:7], x.v[6], x.v[5], x.v[4:1], x.v[0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset asserted: outputs clear without a clock edge, and stay clear across edges
    #2 reset = 1'b0;
    #1 check_now("rst_async", pack(0, 0, 0, 0, 0, 0));
    repeat (3) @(posedge clk);
    #1 check_now("rst_hold", pack(0, 0, 0, 0, 0, 0));
    @(negedge clk);
    #3 reset = 1'b1;
    step(0,0,0, 0,I,0,0,0,0);
    step(0,0,0, 0,I,0,0,0,0);

    // one-shot, period 3, tick every 5 clk; tick in the start cycle is ignored
    period = 8'd3; periodic = 1'b0;
    step(1,1,0, 0,R,1,0,0,0);
    for (int k = 1; k <= 3; k++) begin
      repeat (4) step(0,0,0, k-1,R,1,0,0,0);
      if (k < 3) step(1,0,0, k,R,1,0,0,0);
    end
    step(1,0,0, 3,D,0,1,1,0);
    step(0,0,0, 3,D,0,0,1,0);
    step(1,0,0, 3,D,0,0,1,0);

    // periodic, period 2, six back-to-back ticks
    period = 8'd2; periodic = 1'b1;
    step(0,1,0, 0,R,1,0,0,0);
    for (int i = 1; i <= 6; i++) step(1,0,0, i%2,R,1,(i%2==0)?1:0,i/2,0);
    step(0,1,0, 0,R,1,0,3,0);
    step(0,0,1, 0,P,1,0,3,0);
    step(0,0,1, 0,I,0,0,3,0);

    // pause/resume: paused ticks ignored, period input not reloaded on resume
    period = 8'd4; periodic = 1'b0;
    step(0,1,0, 0,R,1,0,0,0);
    step(1,0,0, 1,R,1,0,0,0);
    step(1,0,1, 1,P,1,0,0,0);
    repeat (3) step(1,0,0, 1,P,1,0,0,0);
    period = 8'd9;
    step(0,1,0, 1,R,1,0,0,0);
    step(1,0,0, 2,R,1,0,0,0);
    step(1,0,0, 3,R,1,0,0,0);
    step(1,0,0, 4,D,0,1,1,0);
    period = 8'd4;
    step(0,1,0, 0,R,1,0,0,0);
    step(0,1,1, 0,P,1,0,0,0);
    step(0,1,0, 0,R,1,0,0,0);
    step(1,0,0, 1,R,1,0,0,0);
    step(1,0,0, 2,R,1,0,0,0);
    step(1,0,0, 3,R,1,0,0,0);
    step(1,0,1, 3,P,1,0,0,0);
    step(0,0,1, 0,I,0,0,0,0);

    // zero period sets sticky err; a valid fresh start clears it; period 1 expires on first tick
    period = 8'd0;
    step(0,1,0, 0,I,0,0,0,1);
    step(0,0,0, 0,I,0,0,0,1);
    period = 8'd1;
    step(1,1,0, 0,R,1,0,0,0);
    step(1,0,0, 1,D,0,1,1,0);
    period = 8'd0;
    step(0,1,0, 1,D,0,0,1,1);
    step(0,0,1, 0,I,0,0,1,1);

    // period 1 periodic: nexp saturates at 15, then async reset mid-run
    period = 8'd1; periodic = 1'b1;
    step(0,1,0, 0,R,1,0,0,0);
    for (int i = 1; i <= 20; i++) step(1,0,0, 0,R,1,1,(i > 15) ? 15 : i,0);
    @(negedge clk);
    tick_in = 1'b0;
    @(posedge clk);
    #3 reset = 1'b0;
    #1 check_now("rst_midrun", pack(0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    #3 check_now("rst_midrun_hold", pack(0, 0, 0, 0, 0, 0));

    if (q.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
